mul_addtree_pipe: RTL and testbench



---
 rtl/mul_addtree_pkg.sv | 17 +
 rtl/mul_addtree_pipe_if.sv | 15 +
 rtl/mul_addtree_level.sv | 33 +++
 rtl/mul_addtree_pipe.sv | 61 ++++++
 tb/tb_mul_addtree_pipe.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/mul_addtree_pkg.sv
// mul_addtree_pkg: shared sizing helpers for the pipelined add-tree multiplier.
// clog2: ceiling log2; stages: pipeline depth (partial-product stage plus
// one stage per tree level); prod_w: product width for a given operand width.
package mul_addtree_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int stages(input int w);
    return clog2(w) + 1;
  endfunction
  function automatic int prod_w(input int w);
    return 2 * w;
  endfunction
endpackage

// File: rtl/mul_addtree_pipe_if.sv
// mul_addtree_pipe_if: operand/product valid-ready bus of the multiplier.
// master: operand producer and product consumer (drives in_valid, mul_a,
// mul_b, out_ready); slave: the multiplier (drives in_ready, out_valid, mul_out).
import mul_addtree_pkg::*;
interface mul_addtree_pipe_if #(parameter int WIDTH = 4);
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          mul_a;
  logic [WIDTH-1:0]          mul_b;
  logic                      out_valid;
  logic                      out_ready;
  logic [prod_w(WIDTH)-1:0]  mul_out;
  modport master(output in_valid, mul_a, mul_b, out_ready, input in_ready, out_valid, mul_out);
  modport slave(input in_valid, mul_a, mul_b, out_ready, output in_ready, out_valid, mul_out);
endinterface

// File: rtl/mul_addtree_level.sv
// mul_addtree_level: one registered add-tree level, summing adjacent term pairs.
// Ports: clk, rst_n (async active-low), adv_i (global advance enable),
// valid_i/terms_i (N terms in), valid_o/terms_o (N/2 registered sums out).
import mul_addtree_pkg::*;
module mul_addtree_level #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    adv_i,
  input  logic                    valid_i,
  input  logic [N-1:0][W-1:0]     terms_i,
  output logic                    valid_o,
  output logic [N/2-1:0][W-1:0]   terms_o
);
  logic [N/2-1:0][W-1:0] terms_d, terms_q;
  logic                  valid_q;
  always_comb begin
    terms_d = '0;
    for (int k = 0; k < N / 2; k++) terms_d[k] = terms_i[2*k] + terms_i[2*k+1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      terms_q <= '0;
      valid_q <= 1'b0;
    end else if (adv_i) begin
      terms_q <= terms_d;
      valid_q <= valid_i;
    end
  assign terms_o = terms_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/mul_addtree_pipe.sv
// mul_addtree_pipe: pipelined add-tree multiplier, one product per clock.
// Ports: clk, rst_n (async active-low), bus (mul_addtree_pipe_if.slave:
// in_valid/in_ready/mul_a/mul_b in, out_valid/out_ready/mul_out out).
// Build option MUL_SIGNED_EN: two's-complement operands and product.
import mul_addtree_pkg::*;
module mul_addtree_pipe #(
  parameter int WIDTH = 4
) (
  input logic                clk,
  input logic                rst_n,
  mul_addtree_pipe_if.slave  bus
);
  localparam int LEVELS = clog2(WIDTH);
  localparam int PW     = prod_w(WIDTH);
  logic [PW-1:0]             a_ext;
  logic [WIDTH-1:0][PW-1:0]  pp_d, pp_q;
  logic                      v0_q;
  logic                      adv;
  // The whole pipe moves as one: any stall at the output freezes every stage.
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;
`ifdef MUL_SIGNED_EN
  assign a_ext = {{WIDTH{bus.mul_a[WIDTH-1]}}, bus.mul_a};
`else
  assign a_ext = {{WIDTH{1'b0}}, bus.mul_a};
`endif
  always_comb begin
    pp_d = '0;
    for (int i = 0; i < WIDTH; i++) pp_d[i] = bus.mul_b[i] ? a_ext << i : '0;
`ifdef MUL_SIGNED_EN
    // The multiplier's sign bit carries weight -2^(WIDTH-1).
    pp_d[WIDTH-1] = -pp_d[WIDTH-1];
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pp_q <= '0;
      v0_q <= 1'b0;
    end else if (adv) begin
      pp_q <= pp_d;
      v0_q <= bus.in_valid;
    end
  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int N = WIDTH >> l;
    logic [N/2-1:0][PW-1:0] t;
    logic                   v;
    if (l == 0) begin : g_first
      mul_addtree_level #(.N(N), .W(PW)) u_lvl (
        .clk(clk), .rst_n(rst_n), .adv_i(adv),
        .valid_i(v0_q), .terms_i(pp_q), .valid_o(v), .terms_o(t)
      );
    end else begin : g_rest
      mul_addtree_level #(.N(N), .W(PW)) u_lvl (
        .clk(clk), .rst_n(rst_n), .adv_i(adv),
        .valid_i(g_lvl[l-1].v), .terms_i(g_lvl[l-1].t), .valid_o(v), .terms_o(t)
      );
    end
  end
  assign bus.out_valid = g_lvl[LEVELS-1].v;
  assign bus.mul_out   = g_lvl[LEVELS-1].t[0];
endmodule

// File: tb/tb_mul_addtree_pipe.sv
// tb_mul_addtree_pipe: directed-vector and scoreboard bench for WIDTH=4 and WIDTH=8.
module tb_mul_addtree_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mul_addtree_pipe_if #(.WIDTH(4)) b4();
  mul_addtree_pipe_if #(.WIDTH(8)) b8();
  mul_addtree_pipe #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  mul_addtree_pipe #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp_u;
    logic [7:0] exp_s;
  } vec_t;
  vec_t vecs[10];
  logic [15:0] q[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b);
`ifdef MUL_SIGNED_EN
    return 16'($signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b}));
`else
    return {8'h00, a} * {8'h00, b};
`endif
  endfunction
  // mode 0: full rate, a=i, b=0xFF; mode 1: full rate with a 5-cycle output stall;
  // mode 2: random in_valid/out_ready at 50%.
  task automatic run8(input int n, input int mode);
    int sent, got, c, first, last, limit;
    logic pend;
    logic [15:0] held;
    sent = 0; got = 0; c = 0; first = -1; last = -1; pend = 1'b0; held = '0;
    limit = n * 8 + 100;
    q.delete();
    while (got < n && c < limit) begin
      if (!pend) begin
        b8.in_valid = (sent < n) && (mode == 2 ? $urandom_range(0, 1) == 1 : 1'b1);
        b8.mul_a = mode == 2 ? 8'($urandom) : 8'(sent);
        b8.mul_b = mode == 0 ? 8'hFF : mode == 1 ? 8'(sent) ^ 8'h5A : 8'($urandom);
      end
      b8.out_ready = mode == 2 ? $urandom_range(0, 1) == 1 : !(mode == 1 && c >= 10 && c < 15);
      #1;
      if (mode == 1 && c == 10) held = b8.mul_out;
      if (mode == 1 && c >= 10 && c < 15) begin
        chk("stall_in_ready", 32'(b8.in_ready), 32'd0);
        chk("stall_out_valid", 32'(b8.out_valid), 32'd1);
        chk("stall_frozen", 32'(b8.mul_out), 32'(held));
      end
      if (b8.in_valid && b8.in_ready) begin
        q.push_back(ref8(b8.mul_a, b8.mul_b));
        sent++;
        pend = 1'b0;
      end else pend = b8.in_valid;
      if (b8.out_valid && b8.out_ready) begin
        if (q.size() == 0) chk("spurious_out", 32'(b8.mul_out), 32'hDEAD);
        else chk("stream_prod", 32'(b8.mul_out), 32'(q.pop_front()));
        if (first < 0) first = c;
        last = c;
        got++;
      end
      tick();
      c++;
    end
    b8.in_valid = 1'b0;
    chk("stream_done", 32'(got), 32'(n));
    chk("queue_empty", 32'(q.size()), 32'd0);
    if (mode == 0) begin
      chk("first_latency8", 32'(first), 32'd4);
      chk("one_per_cycle", 32'(last - first), 32'(n - 1));
    end
    tick();
    chk("idle_after_stream", 32'(b8.out_valid), 32'd0);
  endtask
  initial begin
    vecs[0] = '{4'd15, 4'd15, 8'hE1, 8'h01};
    vecs[1] = '{4'd8,  4'd7,  8'h38, 8'hC8};
    vecs[2] = '{4'd8,  4'd8,  8'h40, 8'h40};
    vecs[3] = '{4'd15, 4'd1,  8'h0F, 8'hFF};
    vecs[4] = '{4'd0,  4'd9,  8'h00, 8'h00};
    vecs[5] = '{4'd3,  4'd5,  8'h0F, 8'h0F};
    vecs[6] = '{4'd7,  4'd7,  8'h31, 8'h31};
    vecs[7] = '{4'd12, 4'd10, 8'h78, 8'h18};
    vecs[8] = '{4'd6,  4'd13, 8'h4E, 8'hEE};
    vecs[9] = '{4'd9,  4'd2,  8'h12, 8'hF2};
    b4.in_valid = 1'b0; b4.mul_a = '0; b4.mul_b = '0; b4.out_ready = 1'b1;
    b8.in_valid = 1'b0; b8.mul_a = '0; b8.mul_b = '0; b8.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid4", 32'(b4.out_valid), 32'd0);
    chk("rst_mul_out4", 32'(b4.mul_out), 32'd0);
    chk("rst_in_ready4", 32'(b4.in_ready), 32'd1);
    chk("rst_out_valid8", 32'(b8.out_valid), 32'd0);
    chk("rst_mul_out8", 32'(b8.mul_out), 32'd0);
    rst_n = 1'b1;
    tick();
    foreach (vecs[i]) begin
      int lat;
      b4.mul_a = vecs[i].a;
      b4.mul_b = vecs[i].b;
      b4.in_valid = 1'b1;
      #1;
      chk("vec_in_ready", 32'(b4.in_ready), 32'd1);
      tick();
      b4.in_valid = 1'b0;
      lat = 1;
      while (!b4.out_valid && lat < 10) begin
        tick();
        lat++;
      end
      chk("vec_latency4", 32'(lat), 32'd3);
`ifdef MUL_SIGNED_EN
      chk("vec_prod4", 32'(b4.mul_out), 32'(vecs[i].exp_s));
`else
      chk("vec_prod4", 32'(b4.mul_out), 32'(vecs[i].exp_u));
`endif
      tick();
      chk("vec_drop4", 32'(b4.out_valid), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      b4.mul_a = 4'(i + 5);
      b4.mul_b = 4'd3;
      b4.in_valid = 1'b1;
      tick();
    end
    b4.in_valid = 1'b0;
    chk("pre_reset_valid", 32'(b4.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(b4.out_valid), 32'd0);
    chk("mid_rst_mul_out", 32'(b4.mul_out), 32'd0);
    chk("mid_rst_in_ready", 32'(b4.in_ready), 32'd1);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("no_stale_out", 32'(b4.out_valid), 32'd0);
    end
    run8(256, 0);
    run8(40, 1);
    run8(10000, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
